mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction-register bits [31:26].
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  output  1 each  PC/memory/IR control.
REQ-007 mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  register-file and ALU-A mux selects.
REQ-008 alu_src_b, alu_op, pc_source  output  2 each  ALU-B mux select, ALU class, PC mux select.
REQ-009 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 The FSM SHALL be Moore: every output SHALL be a decode of the registered state only; unlisted outputs SHALL be 0 in each state.
REQ-012 State encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11; codes 12-15 SHALL go to FETCH.
REQ-013 FETCH: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01, alu_op=00, i_or_d=0; if mem_ready=1 go DECODE, else hold; ir_write and pc_write SHALL be gated by mem_ready.
REQ-014 DECODE: alu_src_b=11, alu_op=00.
REQ-015 DECODE transitions: opcode 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000000 -> R_EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> I_EXEC.
REQ-016 DECODE with any other opcode SHALL go to FETCH and pulse illegal_op for exactly one cycle, in the cycle after DECODE.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go MEM_READ for lw or MEM_WRITE for sw.
REQ-018 The opcode SHALL be sampled in DECODE and MEM_ADDR only; the IR holds it stable.
REQ-019 MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then go MEM_WB.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; go FETCH.
REQ-021 MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then go FETCH; mem_write SHALL stay high for the whole hold.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; go FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; go FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10; go FETCH.
REQ-025 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; go I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; go FETCH.
REQ-026 Latencies SHALL be, with zero-wait memory: lw 5 cycles; sw, R-type, addi 4; beq, j 3. Each mem_ready=0 cycle SHALL add one cycle.
REQ-027 mem_ready SHALL be ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-028 Asserting rst_n low SHALL force state=FETCH and illegal_op=0 immediately, including mid-instruction or during a memory wait.
REQ-029 During reset, outputs SHALL equal the FETCH decode with pc_write=0 and ir_write=0.
REQ-030 The first rising edge after rst_n deasserts SHALL evaluate FETCH normally.

Structure
REQ-031 A shared package SHALL hold the state localparams, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), and the alu_op and pc_source encodings, for reuse by the ALU control and the datapath.
REQ-032 The block SHALL be a single module: one sequential state register, one combinational next-state block and one combinational output decode; it SHALL instantiate no sub-modules.

Verification
REQ-033 Reset, then opcode=100011 with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 in state 4 only.
REQ-034 opcode=101011 with mem_ready=0 for 3 cycles in MEM_WRITE -> state 5 held 4 cycles, mem_write=1 throughout, then FETCH.
REQ-035 opcode=000100 -> states 0,1,8,0; pc_write_cond=1 and pc_source=01 in state 8 only.
REQ-036 opcode=111111 -> states 0,1,0; illegal_op=1 for exactly one cycle; no reg_write or mem_write asserted.
REQ-037 FETCH with mem_ready=0 for 2 cycles -> ir_write and pc_write stay 0 until mem_ready=1, then state=1.
REQ-038 rst_n pulsed low in R_EXEC -> state=0 asynchronously, and reg_write is never asserted for that instruction.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_pkg
//
// Shared definitions for the multi-cycle MIPS control path. This package is
// imported by the main control FSM, the ALU control and the datapath muxes.
//
// Contents:
//   mc_state_e     - control FSM state encodings (4 bits, codes 12-15 unused)
//   OP_*           - instruction opcodes (IR bits [31:26])
//   ALU_OP_*       - ALU class handed to the ALU control block
//   PC_SRC_*       - PC input mux selects
//   ALU_B_*        - ALU B-input mux selects
//   is_legal_op()  - true for every opcode the FSM knows how to execute
// ---------------------------------------------------------------------------
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11
    } mc_state_e;

    // Instruction opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU class: add for address/PC math, subtract for beq compare,
    // funct-field decode for R-type.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // PC mux: ALU result (PC+4), ALUOut register (branch target), jump target
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B mux: register B, constant 4, sign-extended imm, shifted imm
    localparam logic [1:0] ALU_B_REG     = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SHL = 2'b11;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Moore control FSM for a multi-cycle MIPS subset (lw, sw, R-type, beq, j,
// addi). All datapath controls are decoded from the registered state.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   opcode[5:0]    in   IR[31:26], held stable by the IR during execution
//   mem_ready      in   memory access completes this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load if ALU zero (beq)
//   i_or_d         out  memory address: 0 = PC, 1 = ALUOut
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   ir_write       out  IR load
//   mem_to_reg     out  register write data: 1 = memory data register
//   reg_dst        out  destination register: 1 = rd, 0 = rt
//   reg_write      out  register file write enable
//   alu_src_a      out  ALU A: 0 = PC, 1 = register A
//   alu_src_b[1:0] out  ALU B select (ALU_B_*)
//   alu_op[1:0]    out  ALU class (ALU_OP_*)
//   pc_source[1:0] out  PC mux select (PC_SRC_*)
//   illegal_op     out  one-cycle pulse after DECODE saw an unsupported opcode
//   state[3:0]     out  current state encoding, for debug
//
// Memory handshake: the FSM raises mem_read or mem_write and keeps it high
// for as long as it sits in FETCH, MEM_READ or MEM_WRITE; the access is done
// on the first rising edge where mem_ready is 1, and only then does the FSM
// leave that state. mem_ready is a don't-care in every other state.
// ---------------------------------------------------------------------------
module mc_control_fsm
    import mc_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    mc_state_e cur_state;
    mc_state_e next_state;
    logic      illegal_next;

    // -----------------------------------------------------------------------
    // State register (illegal_op is registered alongside so it appears in
    // the cycle after DECODE and clears on reset immediately).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= ST_FETCH;
            illegal_op <= 1'b0;
        end else begin
            cur_state  <= next_state;
            illegal_op <= illegal_next;
        end
    end

    assign state = cur_state;

    // -----------------------------------------------------------------------
    // Next-state logic. The opcode is only looked at in DECODE and MEM_ADDR.
    // -----------------------------------------------------------------------
    always_comb begin
        next_state   = ST_FETCH;
        illegal_next = 1'b0;
        case (cur_state)
            ST_FETCH:     next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_RTYPE:     next_state = ST_R_EXEC;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    OP_ADDI:      next_state = ST_I_EXEC;
                    default:      next_state = ST_FETCH;
                endcase
                illegal_next = !is_legal_op(opcode);
            end
            ST_MEM_ADDR:  next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    next_state = ST_FETCH;
            ST_MEM_WRITE: next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_R_EXEC:    next_state = ST_R_WB;
            ST_R_WB:      next_state = ST_FETCH;
            ST_BRANCH:    next_state = ST_FETCH;
            ST_JUMP:      next_state = ST_FETCH;
            ST_I_EXEC:    next_state = ST_I_WB;
            ST_I_WB:      next_state = ST_FETCH;
            default:      next_state = ST_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. FETCH gates its two load strobes with mem_ready (the
    // instruction is only valid once memory completes) and with rst_n so
    // nothing is loaded while reset holds the FSM in FETCH.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_B_REG;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        case (cur_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
                alu_src_b = ALU_B_FOUR;
                alu_op    = ALU_OP_ADD;
            end
            ST_DECODE: begin
                alu_src_b = ALU_B_IMM_SHL;
                alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_REG;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALU_B_REG;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                alu_op    = ALU_OP_ADD;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Directed bench for mc_control_fsm. Inputs change and outputs are checked
// on the falling clock edge (plus #1 settle); the DUT acts on rising edges.
// Each scenario task begins and ends at a falling edge with the FSM in FETCH.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    mc_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        tests_run++;
        if (pc_write !== 1'b0 || ir_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_gated: pc_write=%b ir_write=%b want 0 0", pc_write, ir_write);
        end
        tests_run++;
        if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || alu_op !== 2'b00 ||
            i_or_d !== 1'b0 || illegal_op !== 1'b0 || reg_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_decode: mem_read=%b alu_src_b=%b alu_op=%b i_or_d=%b illegal_op=%b reg_write=%b want 1 01 00 0 0 0",
                     mem_read, alu_src_b, alu_op, i_or_d, illegal_op, reg_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (state !== 4'd0 || pc_write !== 1'b1 || ir_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: state=%0d pc_write=%b ir_write=%b want 0 1 1",
                     state, pc_write, ir_write);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests_run++;
            if (state !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            tests_run++;
            if (reg_write !== (exp_s[i] == 4'd4) || mem_to_reg !== (exp_s[i] == 4'd4)) begin
                tests_failed++;
                $display("FAIL lw_wb[%0d]: reg_write=%b mem_to_reg=%b want %b", i,
                         reg_write, mem_to_reg, (exp_s[i] == 4'd4));
            end
            tests_run++;
            if (i_or_d !== (exp_s[i] == 4'd3) || alu_src_a !== (exp_s[i] == 4'd2)) begin
                tests_failed++;
                $display("FAIL lw_path[%0d]: i_or_d=%b alu_src_a=%b", i, i_or_d, alu_src_a);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0] exp_s [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        logic       mr    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            tests_run++;
            if (state !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            tests_run++;
            if (mem_write !== (exp_s[i] == 4'd5) || reg_write !== 1'b0) begin
                tests_failed++;
                $display("FAIL sw_strobe[%0d]: mem_write=%b reg_write=%b want %b 0", i,
                         mem_write, reg_write, (exp_s[i] == 4'd5));
            end
            if (i < 7) @(negedge clk);
        end
    endtask

    // R-type, with mem_ready low in states that must ignore it
    task automatic test_rtype();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic       mr    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            tests_run++;
            if (state !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL r_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            tests_run++;
            if (alu_op !== ((exp_s[i] == 4'd6) ? 2'b10 : 2'b00) ||
                reg_write !== (exp_s[i] == 4'd7) || reg_dst !== (exp_s[i] == 4'd7)) begin
                tests_failed++;
                $display("FAIL r_ctrl[%0d]: alu_op=%b reg_write=%b reg_dst=%b", i,
                         alu_op, reg_write, reg_dst);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_beq();
        logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        opcode    = 6'b000100;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (state !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            tests_run++;
            if (pc_write_cond !== (exp_s[i] == 4'd8) ||
                pc_source !== ((exp_s[i] == 4'd8) ? 2'b01 : 2'b00)) begin
                tests_failed++;
                $display("FAIL beq_ctrl[%0d]: pc_write_cond=%b pc_source=%b", i,
                         pc_write_cond, pc_source);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_jump_addi();
        logic [3:0] exp_j [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
        logic [3:0] exp_a [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        opcode    = 6'b000010;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (state !== exp_j[i]) begin
                tests_failed++;
                $display("FAIL j_state[%0d]: got %0d want %0d", i, state, exp_j[i]);
            end
            if (exp_j[i] == 4'd9) begin
                tests_run++;
                if (pc_write !== 1'b1 || pc_source !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL j_ctrl: pc_write=%b pc_source=%b want 1 10", pc_write, pc_source);
                end
            end
            if (i < 3) @(negedge clk);
        end
        opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (state !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, exp_a[i]);
            end
            tests_run++;
            if (reg_write !== (exp_a[i] == 4'd11) || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 ||
                alu_src_b !== ((exp_a[i] == 4'd10) ? 2'b10 :
                               (exp_a[i] == 4'd0)  ? 2'b01 :
                               (exp_a[i] == 4'd1)  ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL addi_ctrl[%0d]: reg_write=%b reg_dst=%b mem_to_reg=%b alu_src_b=%b",
                         i, reg_write, reg_dst, mem_to_reg, alu_src_b);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    // Unsupported opcode; FETCH is stalled afterwards so the pulse width shows
    task automatic test_illegal();
        logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd0, 4'd0};
        logic       exp_i [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       mr    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        opcode = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #1;
            tests_run++;
            if (state !== exp_s[i] || illegal_op !== exp_i[i]) begin
                tests_failed++;
                $display("FAIL illegal[%0d]: state=%0d illegal_op=%b want %0d %b", i,
                         state, illegal_op, exp_s[i], exp_i[i]);
            end
            tests_run++;
            if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_side[%0d]: reg_write=%b mem_write=%b want 0 0", i,
                         reg_write, mem_write);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_fetch_stall();
        logic [3:0] exp_s [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9, 4'd0};
        logic       mr    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #1;
            tests_run++;
            if (state !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL stall_state[%0d]: got %0d want %0d", i, state, exp_s[i]);
            end
            if (i < 3) begin
                tests_run++;
                if (ir_write !== mr[i] || pc_write !== mr[i] || mem_read !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_gate[%0d]: ir_write=%b pc_write=%b mem_read=%b want %b %b 1",
                             i, ir_write, pc_write, mem_read, mr[i], mr[i]);
                end
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_rtype();
        int saw_reg_write = 0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 4'd6) begin
            tests_failed++;
            $display("FAIL midrst_pre: state=%0d want 6", state);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (state !== 4'd0 || illegal_op !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async: state=%0d illegal_op=%b pc_write=%b ir_write=%b want 0 0 0 0",
                     state, illegal_op, pc_write, ir_write);
        end
        if (reg_write) saw_reg_write++;
        @(negedge clk);
        if (reg_write) saw_reg_write++;
        rst_n  = 1'b1;
        opcode = 6'b000010;
        #1;
        if (reg_write) saw_reg_write++;
        @(negedge clk);
        #1;
        if (reg_write) saw_reg_write++;
        tests_run++;
        if (state !== 4'd1) begin
            tests_failed++;
            $display("FAIL midrst_first_edge: state=%0d want 1", state);
        end
        tests_run++;
        if (saw_reg_write !== 0) begin
            tests_failed++;
            $display("FAIL midrst_no_wb: reg_write seen %0d times want 0", saw_reg_write);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 4'd0) begin
            tests_failed++;
            $display("FAIL midrst_recover: state=%0d want 0", state);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_beq();
        test_jump_addi();
        test_illegal();
        test_fetch_stall();
        test_reset_mid_rtype();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
